// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer: initiator for the 4x4 MAC operand interface.
// Clears the MAC, issues one a/b/en beat per accepted operand pair, waits out
// the MAC pipeline and accumulate cycle, then offers the dot product.
// Ports: clk, rst (sync, active-high); start/len/busy command side;
// in_valid/in_ready/in_a/in_b operand stream; mac_a/mac_b/mac_en/mac_clr/mac_out
// to the MAC; res_valid/res_ready/res_data result side.
// Optional: define MAC_SEQ_ABORT_EN to add an abort input that cancels an
// operation in CLEAR, FEED or DRAIN.
module mac_dot_sequencer #(
   parameter int MAC_LATENCY = 3,
   parameter int LEN_W       = 8,
   parameter int ACC_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_a,
   input  logic [3:0]       in_b,
   output logic [3:0]       mac_a,
   output logic [3:0]       mac_b,
   output logic             mac_en,
   output logic             mac_clr,
   input  logic [ACC_W-1:0] mac_out,
`ifdef MAC_SEQ_ABORT_EN
   input  logic             abort,
`endif
   output logic             res_valid,
   input  logic             res_ready,
   output logic [ACC_W-1:0] res_data
);
   localparam int DW = $clog2(MAC_LATENCY + 2);
   // The last en is accumulated MAC_LATENCY+1 edges after DRAIN starts;
   // counting down from this value captures one edge after that.
   localparam logic [DW-1:0] DRAIN_LOAD = DW'(MAC_LATENCY + 1);
   typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
   state_t           state;
   logic [LEN_W-1:0] remaining;
   logic [DW-1:0]    drain;
   assign busy      = state != IDLE;
   assign in_ready  = state == FEED;
   assign mac_clr   = state == CLEAR;
   assign res_valid = state == DONE;
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         mac_a     <= 4'd0;
         mac_b     <= 4'd0;
         mac_en    <= 1'b0;
         res_data  <= '0;
         remaining <= '0;
         drain     <= '0;
      end else begin
         mac_en <= 1'b0;
         case (state)
            IDLE: if (start) begin
               remaining <= len;
               state     <= CLEAR;
            end
            CLEAR: begin
               drain <= DRAIN_LOAD;
               state <= remaining == '0 ? DRAIN : FEED;
            end
            FEED: begin
               drain <= DRAIN_LOAD;
               if (in_valid) begin
                  mac_a     <= in_a;
                  mac_b     <= in_b;
                  mac_en    <= 1'b1;
                  remaining <= remaining - LEN_W'(1);
                  if (remaining == LEN_W'(1)) state <= DRAIN;
               end
            end
            DRAIN: if (drain == '0) begin
               res_data <= mac_out;
               state    <= DONE;
            end else begin
               drain <= drain - DW'(1);
            end
            DONE: if (res_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
`ifdef MAC_SEQ_ABORT_EN
         if (abort && (state == CLEAR || state == FEED || state == DRAIN)) begin
            state  <= IDLE;
            mac_en <= 1'b0;
         end
`endif
      end
   end
endmodule

// File: tb/tb_mac_dot_sequencer.sv
// tb_mac_dot_sequencer: randomized self-checking bench with a behavioural MAC.
module tb_mac_dot_sequencer;
   logic        clk = 0;
   logic        rst = 1;
   logic        start = 0;
   logic [7:0]  len = 0;
   logic        busy;
   logic        in_valid = 0;
   logic        in_ready;
   logic [3:0]  in_a = 0;
   logic [3:0]  in_b = 0;
   logic [3:0]  mac_a;
   logic [3:0]  mac_b;
   logic        mac_en;
   logic        mac_clr;
   logic [15:0] mac_out;
   logic        res_valid;
   logic        res_ready = 0;
   logic [15:0] res_data;
`ifdef MAC_SEQ_ABORT_EN
   logic        abort = 0;
`endif
   int checks = 0;
   int errors = 0;
   int pa[256];
   int pb[256];
   int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
   logic [31:0] m_ready, m_en, m_busy, m_rv, m_clr;

   mac_dot_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .mac_a(mac_a), .mac_b(mac_b), .mac_en(mac_en), .mac_clr(mac_clr),
      .mac_out(mac_out),
`ifdef MAC_SEQ_ABORT_EN
      .abort(abort),
`endif
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
   );

   always #5 clk = ~clk;

   // External MAC: en sampled into a 3-deep multiplier pipeline, product
   // added to the accumulator on the following edge; mac_clr clears all.
   logic [15:0] acc = 0;
   logic [2:0]  pv = 0;
   logic [7:0]  pp0 = 0, pp1 = 0, pp2 = 0;
   assign mac_out = acc;
   always @(posedge clk) begin
      if (mac_clr) begin
         acc <= 0;
         pv  <= 0;
      end else begin
         if (pv[2]) acc <= acc + {8'd0, pp2};
         pv  <= {pv[1:0], mac_en};
         pp2 <= pp1;
         pp1 <= pp0;
         pp0 <= {4'd0, mac_a} * {4'd0, mac_b};
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int dot(input int n);
      int s = 0;
      for (int i = 0; i < n; i++) s += pa[i] * pb[i];
      return s % 65536;
   endfunction

   // One full operation; vmode 0 = in_valid held, 1 = fixed gap pattern,
   // 2 = random. hold = DONE cycles with res_ready low before release.
   task automatic run_op(input string name, input int n, input int vmode,
                         input int hold, input bit poke_start, input int exp);
      int idx = 0, fc = 0, en_cnt = 0, clr_cnt = 0, bad_en = 0, unstable = 0;
      int rv_cyc = -1, last_acc = 1, held = 0, exp_cyc;
      bit prev_acc = 0, acc_now, done = 0;
      logic [15:0] first_data = 0;
      m_ready = 0; m_en = 0; m_busy = 0; m_rv = 0; m_clr = 0;
      @(posedge clk); #1;
      start = 1; len = 8'(n); in_valid = 0; res_ready = hold == 0;
      for (int c = 0; c < 2000 && !done; c++) begin
         @(negedge clk);
         if (c < 32) begin
            m_ready[c] = in_ready; m_en[c] = mac_en; m_busy[c] = busy;
            m_rv[c] = res_valid; m_clr[c] = mac_clr;
         end
         acc_now = in_valid && in_ready;
         if (mac_en !== prev_acc) bad_en++;
         if (mac_en) en_cnt++;
         if (mac_clr) clr_cnt++;
         if (in_ready) fc++;
         if (acc_now) begin idx++; last_acc = c; end
         prev_acc = acc_now;
         if (res_valid) begin
            if (rv_cyc < 0) begin rv_cyc = c; first_data = res_data; end
            else if (res_data !== first_data) unstable++;
            if (res_ready) done = 1;
            held++;
         end
         @(posedge clk); #1;
         start = 0;
         in_valid = 0;
         if (!done && idx < n)
            in_valid = vmode == 0 ? 1'b1 : vmode == 1 ? (fc < 7 ? pat[fc] != 0 : 1'b1)
                                                     : 1'($urandom_range(0, 1));
         in_a = 4'(pa[idx % 256]);
         in_b = 4'(pb[idx % 256]);
         if (done) res_ready = 0;
         else if (rv_cyc >= 0) begin
            res_ready = held >= hold;
            if (poke_start && (held == 2 || res_ready)) start = 1;
         end
      end
      exp_cyc = last_acc + 6;
      checks++; if (!done) begin errors++; $display("FAIL %s timeout: no result handshake", name); end
      checks++; if (en_cnt !== n) begin errors++; $display("FAIL %s mac_en_count: got %0d want %0d", name, en_cnt, n); end
      checks++; if (clr_cnt !== 1) begin errors++; $display("FAIL %s mac_clr_count: got %0d want 1", name, clr_cnt); end
      checks++; if (bad_en !== 0) begin errors++; $display("FAIL %s mac_en_alignment: got %0d bad cycles want 0", name, bad_en); end
      checks++; if (first_data !== 16'(exp)) begin errors++; $display("FAIL %s res_data: got %0d want %0d", name, first_data, exp); end
      checks++; if (rv_cyc !== exp_cyc) begin errors++; $display("FAIL %s res_valid_cycle: got %0d want %0d", name, rv_cyc, exp_cyc); end
      checks++; if (unstable !== 0) begin errors++; $display("FAIL %s res_data_stable: got %0d changes want 0", name, unstable); end
      checks++; if (held !== hold + 1) begin errors++; $display("FAIL %s done_cycles: got %0d want %0d", name, held, hold + 1); end
      @(negedge clk);
      checks++; if ({busy, res_valid} !== 2'b00) begin errors++; $display("FAIL %s idle_after: got busy,res_valid=%b want 00", name, {busy, res_valid}); end
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      checks++;
      if ({busy, in_ready, mac_en, mac_clr, res_valid, mac_a, mac_b, res_data} !== 29'd0) begin
         errors++;
         $display("FAIL reset_values: got busy=%b rdy=%b en=%b clr=%b rv=%b a=%0d b=%0d data=%0d want all 0",
                  busy, in_ready, mac_en, mac_clr, res_valid, mac_a, mac_b, res_data);
      end
   endtask

   task automatic test_back_to_back;
      pa[0] = 2; pb[0] = 3; pa[1] = 4; pb[1] = 5; pa[2] = 15; pb[2] = 15;
      run_op("b2b", 3, 0, 0, 0, 251);
      checks++; if (m_ready !== 32'h1C) begin errors++; $display("FAIL b2b in_ready_cycles: got %h want 0000001c", m_ready); end
      checks++; if (m_en !== 32'h38) begin errors++; $display("FAIL b2b mac_en_cycles: got %h want 00000038", m_en); end
      checks++; if (m_clr !== 32'h2) begin errors++; $display("FAIL b2b mac_clr_cycles: got %h want 00000002", m_clr); end
      checks++; if (m_busy !== 32'h7FE) begin errors++; $display("FAIL b2b busy_cycles: got %h want 000007fe", m_busy); end
      checks++; if (m_rv !== 32'h400) begin errors++; $display("FAIL b2b res_valid_cycles: got %h want 00000400", m_rv); end
   endtask

   task automatic test_zero_length;
      run_op("zero", 0, 0, 0, 0, 0);
   endtask

   task automatic test_gapped;
      for (int i = 0; i < 4; i++) begin pa[i] = i + 1; pb[i] = i + 1; end
      run_op("gapped", 4, 1, 0, 0, 30);
   endtask

   task automatic test_backpressure;
      for (int i = 0; i < 3; i++) begin pa[i] = $urandom_range(0, 15); pb[i] = $urandom_range(0, 15); end
      run_op("backpressure", 3, 0, 5, 1, dot(3));
   endtask

   task automatic test_reset_mid;
      int got = 0;
      for (int i = 0; i < 5; i++) begin pa[i] = 9; pb[i] = 7; end
      @(posedge clk); #1;
      start = 1; len = 8'd5; in_valid = 1; in_a = 4'd9; in_b = 4'd7;
      @(posedge clk); #1 start = 0;
      for (int c = 0; c < 20 && got < 2; c++) begin
         @(negedge clk);
         if (in_valid && in_ready) got++;
         @(posedge clk); #1;
      end
      in_valid = 0; rst = 1;
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      checks++;
      if ({busy, in_ready, mac_en, mac_clr, res_valid, mac_a, mac_b, res_data} !== 29'd0) begin
         errors++;
         $display("FAIL reset_mid_values: got busy=%b rdy=%b en=%b clr=%b rv=%b a=%0d b=%0d data=%0d want all 0",
                  busy, in_ready, mac_en, mac_clr, res_valid, mac_a, mac_b, res_data);
      end
      pa[0] = 3; pb[0] = 4; pa[1] = 5; pb[1] = 6;
      run_op("after_reset", 2, 0, 0, 0, 42);
   endtask

   task automatic test_random;
      for (int k = 0; k < 6; k++) begin
         int n = $urandom_range(0, 12);
         for (int i = 0; i < n; i++) begin pa[i] = $urandom_range(0, 15); pb[i] = $urandom_range(0, 15); end
         run_op("random", n, 2, $urandom_range(0, 3), 1'($urandom_range(0, 1)), dot(n));
      end
   endtask

   task automatic test_max_length;
      for (int i = 0; i < 255; i++) begin pa[i] = 15; pb[i] = 15; end
      run_op("max_len", 255, 0, 0, 0, 57375);
   endtask

   initial begin
      test_reset;
      test_back_to_back;
      test_zero_length;
      test_gapped;
      test_backpressure;
      test_reset_mid;
      test_random;
      test_max_length;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
